wb_timer_irq: RTL and testbench
===============================

// Module: wb_timer_irq
// PURPOSE
//  WB-slave down-counting timer with interrupt; next slave on the SoC WB-cross, at 0x012000 / 4KB.
//  o_irq drives the MB-Lite sys_int_i input, which is currently tied to 1'b0.
//  Provides a periodic or one-shot time base for firmware at 1us resolution (default, 50MHz clock).
// PARAMETERS
//  p_PRESC  50  clock cycles per timer tick (>=1); tick period = p_PRESC * T(i_clk)
// PORTS
//  i_clk       in   1   system clock, 50MHz
//  i_arst_n    in   1   asynchronous active-low reset
//  iv_wbs_adr  in   4   byte address; word select = adr[3:2]; adr[1:0] ignored
//  iv_wbs_dat  in   32  write data
//  i_wbs_we    in   1   write enable
//  i_wbs_stb   in   1   strobe
//  iv_wbs_sel  in   4   byte-lane select; sel[n] enables dat[8n+7:8n] on writes
//  i_wbs_cyc   in   1   bus cycle (already gated by the cross decode)
//  ov_wbs_dat  out  32  read data, valid while o_wbs_ack=1
//  o_wbs_ack   out  1   transfer acknowledge
//  o_irq       out  1   level interrupt, registered
// BEHAVIOUR
//  Registers:
//   0x0 CTRL  RW  [0] EN, [1] AUTO (reload on expiry), [2] IE; [31:3] read 0
//   0x4 LOAD  RW  32b reload value
//   0x8 COUNT RO  32b current count; writes ignored
//   0xC STAT  RW1C  [0] EXP (expired flag); write 1 clears; write 0 no effect
//  Reset (i_arst_n=0, async): CTRL=0, LOAD=0, COUNT=0, EXP=0, prescaler=0,
//   o_wbs_ack=0, ov_wbs_dat=0, o_irq=0.
//  WB handshake:
//   - Access = cyc & stb & ~ack. o_wbs_ack is registered: 1 cycle after access, high for exactly 1 cycle.
//   - Held stb therefore gives ack every 2nd cycle.
//   - Writes are applied on the access edge; read data is registered with the ack.
//  Prescaler:
//   - Counts 0..p_PRESC-1 while EN=1; held at 0 while EN=0.
//   - tick = 1 for 1 cycle when prescaler = p_PRESC-1. With p_PRESC=1, tick=1 every cycle while EN=1.
//  Count FSM (states IDLE, RUN):
//   - IDLE (EN=0): COUNT holds its value.
//   - CTRL write with EN 0->1: COUNT<=LOAD, prescaler<=0, go to RUN.
//   - LOAD write while EN=0: COUNT<=LOAD as well. LOAD write while EN=1: LOAD only.
//   - RUN, tick, COUNT!=0: COUNT<=COUNT-1.
//   - RUN, tick, COUNT==0: EXP<=1.
//       AUTO=1: COUNT<=LOAD, stay in RUN.
//       AUTO=0: EN<=0, COUNT stays 0, go to IDLE.
//   - CTRL write with EN=0: go to IDLE immediately; COUNT frozen.
//  Period: LOAD=N gives expiry every (N+1)*p_PRESC cycles.
//  LOAD=0 with AUTO=1: expires on every tick.
//  o_irq <= EXP & IE (1-cycle register latency).
//  Simultaneous events:
//   - Expiry and EXP W1C in the same cycle: set wins, EXP=1.
//   - CTRL write and expiry in the same cycle: CTRL write data wins for EN.
//  Count wrap-around is impossible: decrement only occurs when COUNT!=0.
//  Mid-operation reset: all state clears asynchronously. A pending ack is dropped.
// TESTING
//  T1 reset: assert i_arst_n=0 mid-RUN -> all regs read 0, o_irq=0, o_wbs_ack=0 same cycle.
//  T2 one-shot: p_PRESC=4, LOAD=3, CTRL=0x5
//     -> EXP=1 and o_irq=1 after 16 cycles (+1 for irq register); CTRL reads 0x4; COUNT reads 0.
//  T3 periodic: LOAD=9, CTRL=0x7, p_PRESC=50 -> EXP set every 500 cycles;
//     W1C STAT=1 clears o_irq next cycle; next expiry re-asserts it.
//  T4 bus: write LOAD=0xAABBCCDD with sel=4'b0010 onto LOAD=0 -> reads 0x0000CC00.
//     Held stb -> ack pulses on alternate cycles.
//     Write COUNT=0x1234 -> COUNT unchanged.
//  T5 collision: force W1C of STAT on the exact expiry cycle -> EXP reads 1, o_irq stays 1.
//  T6 stop/restart: clear EN at COUNT=5 -> COUNT holds 5.
//     Re-enable with LOAD=7 -> COUNT restarts from 7.

Source files
------------

// File: rtl/wb_timer_irq.sv
// ---------------------------------------------------------------------------
// wb_timer_irq
//
// Wishbone slave down-counting timer with a level interrupt.
// Gives firmware a periodic or one-shot time base. With the default
// p_PRESC of 50 and a 50 MHz clock, one timer tick is 1 us.
//
// Register map (word select = iv_wbs_adr[3:2]):
//   0x0 CTRL  RW    [0] EN, [1] AUTO (reload on expiry), [2] IE; [31:3] read 0
//   0x4 LOAD  RW    32-bit reload value
//   0x8 COUNT RO    current count, writes ignored
//   0xC STAT  RW1C  [0] EXP, write 1 clears, write 0 has no effect
//
// Ports:
//   i_clk        system clock
//   i_arst_n     asynchronous active-low reset
//   iv_wbs_adr   byte address, bits [1:0] ignored
//   iv_wbs_dat   write data
//   i_wbs_we     write enable
//   i_wbs_stb    strobe
//   iv_wbs_sel   byte-lane select for writes
//   i_wbs_cyc    bus cycle
//   ov_wbs_dat   registered read data, valid with o_wbs_ack
//   o_wbs_ack    registered single-cycle acknowledge
//   o_irq        registered level interrupt (EXP & IE)
// ---------------------------------------------------------------------------
module wb_timer_irq #(
  parameter int p_PRESC = 50
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic [3:0]  iv_wbs_adr,
  input  logic [31:0] iv_wbs_dat,
  input  logic        i_wbs_we,
  input  logic        i_wbs_stb,
  input  logic [3:0]  iv_wbs_sel,
  input  logic        i_wbs_cyc,
  output logic [31:0] ov_wbs_dat,
  output logic        o_wbs_ack,
  output logic        o_irq
);

  // Prescaler width; a 1-bit counter is kept even for p_PRESC=1 so the
  // compare below stays legal.
  localparam int PW = (p_PRESC > 1) ? $clog2(p_PRESC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(p_PRESC - 1);

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_LOAD  = 2'd1;
  localparam logic [1:0] ADDR_COUNT = 2'd2;
  localparam logic [1:0] ADDR_STAT  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          ctrl_auto;
  logic          ctrl_ie;
  logic          ctrl_en;
  logic [31:0]   load_reg;
  logic [31:0]   count_reg;
  logic [31:0]   count_next;
  logic          exp_flag;
  logic          exp_next;
  logic          exp_set;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic          tick;

  logic          access;
  logic          wr_acc;
  logic          rd_acc;
  logic          wr_ctrl;
  logic          wr_load;
  logic          wr_stat;
  logic          en_wdata;
  logic          exp_clear;
  logic [31:0]   load_wdata;
  logic [31:0]   rd_mux;
  logic          unused_adr;

  // Byte-lane merge: only lanes with sel set take the new data.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // The byte offset bits carry no meaning for a word-only register file.
  assign unused_adr = ^iv_wbs_adr[1:0];

  // A new access is only accepted while no ack is outstanding, which is
  // what makes a held strobe complete on every second cycle.
  assign access  = i_wbs_cyc & i_wbs_stb & ~o_wbs_ack;
  assign wr_acc  = access & i_wbs_we;
  assign rd_acc  = access & ~i_wbs_we;
  assign wr_ctrl = wr_acc & (iv_wbs_adr[3:2] == ADDR_CTRL);
  assign wr_load = wr_acc & (iv_wbs_adr[3:2] == ADDR_LOAD);
  assign wr_stat = wr_acc & (iv_wbs_adr[3:2] == ADDR_STAT);

  // EN lives in the FSM state; a CTRL write with lane 0 disabled keeps it.
  assign ctrl_en    = (state == ST_RUN);
  assign en_wdata   = iv_wbs_sel[0] ? iv_wbs_dat[0] : ctrl_en;
  assign exp_clear  = wr_stat & iv_wbs_sel[0] & iv_wbs_dat[0];
  assign load_wdata = merge_bytes(load_reg, iv_wbs_dat, iv_wbs_sel);

  assign tick = ctrl_en && (presc == PRESC_MAX);

  // Count FSM next-state. A CTRL write overrides whatever the expiry logic
  // decided for EN; stopping freezes COUNT even if a tick lands that cycle.
  always_comb begin
    state_next = state;
    count_next = count_reg;
    exp_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_ctrl && en_wdata) begin
          state_next = ST_RUN;
          count_next = load_reg;
        end else if (wr_load) begin
          count_next = load_wdata;
        end
      end
      ST_RUN: begin
        if (tick) begin
          if (count_reg != 32'd0) begin
            count_next = count_reg - 32'd1;
          end else begin
            exp_set = 1'b1;
            if (ctrl_auto) begin
              count_next = load_reg;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
        if (wr_ctrl) begin
          if (en_wdata) begin
            state_next = ST_RUN;
          end else begin
            state_next = ST_IDLE;
            count_next = count_reg;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Prescaler restarts from zero on every tick and whenever the timer is
  // (re)started or stopped, so the first period after enable is full length.
  always_comb begin
    presc_next = '0;
    if ((state == ST_RUN) && (state_next == ST_RUN) && !tick) begin
      presc_next = presc + 1'b1;
    end
  end

  // Expiry set has priority over a simultaneous W1C.
  always_comb begin
    exp_next = exp_flag;
    if (exp_set) begin
      exp_next = 1'b1;
    end else if (exp_clear) begin
      exp_next = 1'b0;
    end
  end

  // Read mux, sampled into the read-data register on a read access.
  always_comb begin
    rd_mux = 32'd0;
    case (iv_wbs_adr[3:2])
      ADDR_CTRL:  rd_mux = {29'd0, ctrl_ie, ctrl_auto, ctrl_en};
      ADDR_LOAD:  rd_mux = load_reg;
      ADDR_COUNT: rd_mux = count_reg;
      ADDR_STAT:  rd_mux = {31'd0, exp_flag};
      default:    rd_mux = 32'd0;
    endcase
  end

  // Timer state registers.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state     <= ST_IDLE;
      count_reg <= 32'd0;
      presc     <= '0;
      exp_flag  <= 1'b0;
    end else begin
      state     <= state_next;
      count_reg <= count_next;
      presc     <= presc_next;
      exp_flag  <= exp_next;
    end
  end

  // Software-written configuration registers.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      ctrl_auto <= 1'b0;
      ctrl_ie   <= 1'b0;
      load_reg  <= 32'd0;
    end else begin
      if (wr_ctrl && iv_wbs_sel[0]) begin
        ctrl_auto <= iv_wbs_dat[1];
        ctrl_ie   <= iv_wbs_dat[2];
      end
      if (wr_load) begin
        load_reg <= load_wdata;
      end
    end
  end

  // Bus response and interrupt output registers.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_wbs_ack  <= 1'b0;
      ov_wbs_dat <= 32'd0;
      o_irq      <= 1'b0;
    end else begin
      o_wbs_ack  <= access;
      ov_wbs_dat <= rd_acc ? rd_mux : 32'd0;
      o_irq      <= exp_flag & ctrl_ie;
    end
  end

endmodule

// File: tb/tb_wb_timer_irq.sv
// ---------------------------------------------------------------------------
// tb_wb_timer_irq
//
// Self-checking bench for wb_timer_irq with p_PRESC=4. Register reads push
// their expected value onto a scoreboard queue; a monitor pops and compares
// whenever a read is acknowledged. Interrupt and ack timing is checked
// cycle-by-cycle against hand-derived edge counts.
// ---------------------------------------------------------------------------
module tb_wb_timer_irq;

  localparam int PRESC = 4;

  localparam logic [3:0] A_CTRL  = 4'h0;
  localparam logic [3:0] A_LOAD  = 4'h4;
  localparam logic [3:0] A_COUNT = 4'h8;
  localparam logic [3:0] A_STAT  = 4'hC;

  logic        clk;
  logic        arstN;
  logic [3:0]  wbsAdr;
  logic [31:0] wbsDatW;
  logic        wbsWe;
  logic        wbsStb;
  logic [3:0]  wbsSel;
  logic        wbsCyc;
  logic [31:0] wbsDatR;
  logic        wbsAck;
  logic        irq;

  int          checks;
  int          failures;
  logic        lastRead;
  string       tagQ[$];
  logic [31:0] expQ[$];

  wb_timer_irq #(.p_PRESC(PRESC)) dut (
    .i_clk      (clk),
    .i_arst_n   (arstN),
    .iv_wbs_adr (wbsAdr),
    .iv_wbs_dat (wbsDatW),
    .i_wbs_we   (wbsWe),
    .i_wbs_stb  (wbsStb),
    .iv_wbs_sel (wbsSel),
    .i_wbs_cyc  (wbsCyc),
    .ov_wbs_dat (wbsDatR),
    .o_wbs_ack  (wbsAck),
    .o_irq      (irq)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Remember whether the access taken on this edge was a read.
  always @(posedge clk) begin
    lastRead = wbsCyc & wbsStb & ~wbsAck & ~wbsWe;
  end

  // Scoreboard monitor: every acknowledged read pops one expectation.
  always @(negedge clk) begin
    if (wbsAck && lastRead) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_unexpected_ack", 32'(expQ.size()), 32'd1);
      end else begin
        checkOutput(tagQ.pop_front(), wbsDatR, expQ.pop_front());
      end
    end
  end

  // Advance n edges and land 1 ns after the last one.
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One Wishbone transfer; the access happens on the first edge after the
  // drive, and the task returns 1 ns after the ack edge.
  task automatic applyStimulus(input logic we, input logic [3:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel);
    logic gotAck;
    gotAck = 1'b0;
    @(posedge clk);
    #1;
    wbsCyc  = 1'b1;
    wbsStb  = 1'b1;
    wbsWe   = we;
    wbsAdr  = adr;
    wbsDatW = dat;
    wbsSel  = sel;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (wbsAck) begin
        gotAck = 1'b1;
        break;
      end
    end
    wbsCyc = 1'b0;
    wbsStb = 1'b0;
    wbsWe  = 1'b0;
    checkOutput("ack_seen", 32'(gotAck), 32'd1);
  endtask

  task automatic wbWrite(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    applyStimulus(1'b1, adr, dat, sel);
  endtask

  task automatic wbRead(input logic [3:0] adr, input logic [31:0] exp, input string tag);
    tagQ.push_back(tag);
    expQ.push_back(exp);
    applyStimulus(1'b0, adr, 32'd0, 4'hF);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    lastRead = 1'b0;
    arstN    = 1'b0;
    wbsAdr   = 4'h0;
    wbsDatW  = 32'd0;
    wbsWe    = 1'b0;
    wbsStb   = 1'b0;
    wbsSel   = 4'h0;
    wbsCyc   = 1'b0;

    // Power-on reset state.
    #12;
    checkOutput("rst_ack", 32'(wbsAck), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_dat", wbsDatR, 32'd0);
    waitCycles(2);
    arstN = 1'b1;
    waitCycles(1);
    wbRead(A_CTRL,  32'd0, "rst_ctrl");
    wbRead(A_LOAD,  32'd0, "rst_load");
    wbRead(A_COUNT, 32'd0, "rst_count");
    wbRead(A_STAT,  32'd0, "rst_stat");

    // Bus behaviour: byte lanes, read-only COUNT, CTRL upper bits.
    wbWrite(A_LOAD, 32'hAABBCCDD, 4'b0010);
    wbRead(A_LOAD,  32'h0000CC00, "bus_sel_load");
    wbRead(A_COUNT, 32'h0000CC00, "bus_idle_count_follows");
    wbWrite(A_COUNT, 32'h00001234, 4'hF);
    wbRead(A_COUNT, 32'h0000CC00, "bus_count_ro");
    wbWrite(A_CTRL, 32'hFFFFFFF8, 4'hF);
    wbRead(A_CTRL,  32'h00000000, "bus_ctrl_upper");

    // Held strobe: ack on alternate cycles.
    @(posedge clk);
    #1;
    wbsCyc  = 1'b1;
    wbsStb  = 1'b1;
    wbsWe   = 1'b1;
    wbsAdr  = A_LOAD;
    wbsDatW = 32'h55667788;
    wbsSel  = 4'hF;
    for (int i = 0; i < 6; i++) begin
      waitCycles(1);
      checkOutput($sformatf("bus_held_ack%0d", i), 32'(wbsAck), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    wbsCyc = 1'b0;
    wbsStb = 1'b0;
    wbsWe  = 1'b0;
    wbRead(A_LOAD, 32'h55667788, "bus_held_load");

    // One-shot: LOAD=3, CTRL=EN|IE; expiry on edge 16, irq on edge 17.
    wbWrite(A_LOAD, 32'd3, 4'hF);
    wbWrite(A_CTRL, 32'h5, 4'hF);
    waitCycles(16);
    checkOutput("os_irq_e16", 32'(irq), 32'd0);
    waitCycles(1);
    checkOutput("os_irq_e17", 32'(irq), 32'd1);
    wbRead(A_STAT,  32'd1, "os_stat");
    wbRead(A_CTRL,  32'h4, "os_ctrl");
    wbRead(A_COUNT, 32'd0, "os_count");

    // STAT write 0 has no effect; write 1 clears, irq drops a cycle later.
    wbWrite(A_STAT, 32'd0, 4'hF);
    wbRead(A_STAT, 32'd1, "w1c_zero");
    wbWrite(A_STAT, 32'd1, 4'hF);
    checkOutput("w1c_irq_hold", 32'(irq), 32'd1);
    waitCycles(1);
    checkOutput("w1c_irq_drop", 32'(irq), 32'd0);

    // Periodic: LOAD=2, CTRL=EN|AUTO|IE, expiry every 12 cycles.
    wbWrite(A_LOAD, 32'd2, 4'hF);
    wbWrite(A_CTRL, 32'h7, 4'hF);
    waitCycles(12);
    checkOutput("per_irq_e12", 32'(irq), 32'd0);
    waitCycles(1);
    checkOutput("per_irq_e13", 32'(irq), 32'd1);
    wbWrite(A_STAT, 32'd1, 4'hF);
    checkOutput("per_irq_e15", 32'(irq), 32'd1);
    waitCycles(1);
    checkOutput("per_irq_e16", 32'(irq), 32'd0);
    waitCycles(8);
    checkOutput("per_irq_e24", 32'(irq), 32'd0);
    waitCycles(1);
    checkOutput("per_irq_e25", 32'(irq), 32'd1);

    // Collision: W1C access lands exactly on the expiry edge 36.
    wbWrite(A_STAT, 32'd1, 4'hF);
    waitCycles(7);
    wbWrite(A_STAT, 32'd1, 4'hF);
    checkOutput("col_irq_e36", 32'(irq), 32'd0);
    waitCycles(1);
    checkOutput("col_irq_e37", 32'(irq), 32'd1);
    wbRead(A_STAT, 32'd1, "col_stat");
    wbWrite(A_CTRL, 32'd0, 4'hF);
    wbWrite(A_STAT, 32'd1, 4'hF);
    wbRead(A_STAT, 32'd0, "col_stat_cleared");

    // Stop at COUNT=5, then restart from a new LOAD.
    wbWrite(A_LOAD, 32'd9, 4'hF);
    wbWrite(A_CTRL, 32'h1, 4'hF);
    waitCycles(15);
    wbWrite(A_CTRL, 32'h0, 4'hF);
    wbRead(A_COUNT, 32'd5, "stop_count");
    waitCycles(20);
    wbRead(A_COUNT, 32'd5, "stop_count_held");
    wbRead(A_CTRL,  32'd0, "stop_ctrl");
    wbWrite(A_LOAD, 32'd7, 4'hF);
    wbWrite(A_CTRL, 32'h1, 4'hF);
    wbRead(A_COUNT, 32'd7, "restart_count");
    wbWrite(A_CTRL, 32'h0, 4'hF);

    // Reset mid-run with an ack pending.
    wbWrite(A_LOAD, 32'd0, 4'hF);
    wbWrite(A_CTRL, 32'h7, 4'hF);
    waitCycles(10);
    checkOutput("mid_irq_before", 32'(irq), 32'd1);
    wbsCyc = 1'b1;
    wbsStb = 1'b1;
    wbsWe  = 1'b0;
    wbsAdr = A_STAT;
    wbsSel = 4'hF;
    waitCycles(1);
    checkOutput("mid_ack_before", 32'(wbsAck), 32'd1);
    #2;
    arstN = 1'b0;
    #1;
    checkOutput("mid_rst_ack", 32'(wbsAck), 32'd0);
    checkOutput("mid_rst_irq", 32'(irq), 32'd0);
    checkOutput("mid_rst_dat", wbsDatR, 32'd0);
    wbsCyc = 1'b0;
    wbsStb = 1'b0;
    waitCycles(2);
    arstN = 1'b1;
    waitCycles(1);
    wbRead(A_CTRL,  32'd0, "mid_ctrl");
    wbRead(A_LOAD,  32'd0, "mid_load");
    wbRead(A_COUNT, 32'd0, "mid_count");
    wbRead(A_STAT,  32'd0, "mid_stat");
    checkOutput("mid_irq_after", 32'(irq), 32'd0);

    waitCycles(2);
    checkOutput("sb_drain", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
